// File: rtl/shift_arbiter.sv
// ---------------------------------------------------------------------------
// shift_arbiter
// Shares one 32-bit barrel shifter between NUM_REQ requesters. Each cycle at
// most one pending request is granted by round-robin. The winner's operand,
// mode and amount are driven onto the shifter inputs, and the shifter result
// is captured with the winner's ID in a single-entry response register. That
// register is drained by a valid/ready handshake.
//
// Build option:
//   SHIFT_ARB_FIXED_PRIO_EN - when defined, the lowest index always wins and
//                             there is no rotating pointer. The handshake and
//                             latency are unchanged.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   req_valid/req_ready   per-requester handshake (req_ready is one-hot)
//   req_data/sel/amt      packed per-requester operand, mode, shift amount
//   sh_in/sh_sel/sh_B     drive to the external combinational shifter
//   sh_out                shifter result
//   rsp_valid/rsp_ready   response handshake
//   rsp_data/rsp_id       captured result and owning requester index
// ---------------------------------------------------------------------------
module shift_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ*32-1:0] req_data,
  input  logic [NUM_REQ*2-1:0] req_sel,
  input  logic [NUM_REQ*5-1:0] req_amt,
  output logic [31:0]          sh_in,
  output logic [1:0]           sh_sel,
  output logic [4:0]           sh_B,
  input  logic [31:0]          sh_out,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [31:0]          rsp_data,
  output logic [IDW-1:0]       rsp_id
);

  logic           w_canIssue;
  logic           w_found;
  logic           w_grant;
  logic [IDW-1:0] w_winner;
  logic [IDW-1:0] w_ptr;

  logic           r_rspValid;
  logic [31:0]    r_rspData;
  logic [IDW-1:0] r_rspId;

  // A new result may be captured when the buffer is empty or is being drained
  // in this same cycle.
  assign w_canIssue = ~r_rspValid | rsp_ready;

`ifdef SHIFT_ARB_FIXED_PRIO_EN
  assign w_ptr = '0;
`else
  logic [IDW-1:0] r_ptr;
  logic [IDW-1:0] w_ptrNext;

  assign w_ptr     = r_ptr;
  assign w_ptrNext = (w_winner == IDW'(NUM_REQ - 1)) ? '0 : w_winner + IDW'(1);

  // The rotating priority pointer moves just past the requester that won.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_grant) begin
      r_ptr <= w_ptrNext;
    end
  end
`endif

  // Search upward from the pointer, wrapping, for the first valid requester.
  always_comb begin
    int idx;
    w_found  = 1'b0;
    w_winner = '0;
    idx      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(w_ptr) + k) % NUM_REQ;
      if (!w_found && (|(req_valid & (NUM_REQ'(1) << idx)))) begin
        w_found  = 1'b1;
        w_winner = IDW'(idx);
      end
    end
  end

  // Reset suppresses any grant so nothing is accepted while rst is high.
  assign w_grant = w_found & w_canIssue & ~rst;

  // One-hot grant and the shifter input mux; everything is zero without a grant.
  always_comb begin
    req_ready = '0;
    sh_in     = '0;
    sh_sel    = '0;
    sh_B      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant && (w_winner == IDW'(i))) begin
        req_ready[i] = 1'b1;
        sh_in        = req_data[32*i +: 32];
        sh_sel       = req_sel[2*i +: 2];
        sh_B         = req_amt[5*i +: 5];
      end
    end
  end

  // Single-entry response register: a grant overwrites it (even while it is
  // being drained); a drain with no grant simply empties it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rspValid <= 1'b0;
      r_rspData  <= '0;
      r_rspId    <= '0;
    end else if (w_grant) begin
      r_rspValid <= 1'b1;
      r_rspData  <= sh_out;
      r_rspId    <= w_winner;
    end else if (rsp_ready) begin
      r_rspValid <= 1'b0;
    end
  end

  assign rsp_valid = r_rspValid;
  assign rsp_data  = r_rspData;
  assign rsp_id    = r_rspId;

endmodule

// File: tb/tb_shift_arbiter.sv
// ---------------------------------------------------------------------------
// tb_shift_arbiter
// Directed and randomized bench for shift_arbiter with four requesters. The
// bench also plays the role of the external barrel shifter. A transaction
// level model tracks the pointer and the response buffer, and predicts each
// grant and response from the arbitration rules.
// ---------------------------------------------------------------------------
module tb_shift_arbiter;

  localparam int N   = 4;
  localparam int IDW = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [N*32-1:0]   req_data;
  logic [N*2-1:0]    req_sel;
  logic [N*5-1:0]    req_amt;
  logic [31:0]       sh_in;
  logic [1:0]        sh_sel;
  logic [4:0]        sh_B;
  logic [31:0]       sh_out;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [31:0]       rsp_data;
  logic [IDW-1:0]    rsp_id;

  int checks = 0;
  int errors = 0;

  // Requester-side state, packed onto the buses below.
  bit          opValid [N];
  logic [31:0] opData  [N];
  logic [1:0]  opSel   [N];
  logic [4:0]  opAmt   [N];

  // Reference model of the arbiter.
  int          mPtr   = 0;
  bit          mValid = 1'b0;
  logic [31:0] mData  = '0;
  int          mId    = 0;
  int          lastWinner;

  int rrOrder [5] = '{0, 1, 2, 3, 0};

  shift_arbiter #(.NUM_REQ(N), .IDW(IDW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .req_sel   (req_sel),
    .req_amt   (req_amt),
    .sh_in     (sh_in),
    .sh_sel    (sh_sel),
    .sh_B      (sh_B),
    .sh_out    (sh_out),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id)
  );

  always #5 clk = ~clk;

  // Shift semantics: bit 1 selects left (always logical), else bit 0 selects
  // arithmetic right.
  function automatic logic [31:0] refShift(input logic [31:0] d, input logic [1:0] s,
                                           input logic [4:0] a);
    if (s[1])      return d << a;
    else if (s[0]) return 32'($signed(d) >>> a);
    else           return d >> a;
  endfunction

  // The external shifter.
  always_comb sh_out = refShift(sh_in, sh_sel, sh_B);

  // Pack the per-requester fields onto the DUT buses.
  always_comb begin
    req_valid = '0;
    req_data  = '0;
    req_sel   = '0;
    req_amt   = '0;
    for (int i = 0; i < N; i++) begin
      req_valid[i]       = opValid[i];
      req_data[32*i +: 32] = opData[i];
      req_sel[2*i +: 2]  = opSel[i];
      req_amt[5*i +: 5]  = opAmt[i];
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int pickWinner();
    int p;
`ifdef SHIFT_ARB_FIXED_PRIO_EN
    p = 0;
`else
    p = mPtr;
`endif
    for (int k = 0; k < N; k++)
      if (opValid[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  // One clock cycle: check the combinational grant, clock, then check the
  // captured response against the model.
  task automatic applyStimulus(input string tag);
    int           w;
    logic [N-1:0] expReady;
    logic [31:0]  expIn;
    logic [1:0]   expSel;
    logic [4:0]   expAmt;
    #2;
    w = (!mValid || rsp_ready) ? pickWinner() : -1;
    expReady = '0;
    expIn    = '0;
    expSel   = '0;
    expAmt   = '0;
    if (w >= 0) begin
      expReady[w] = 1'b1;
      expIn       = opData[w];
      expSel      = opSel[w];
      expAmt      = opAmt[w];
    end
    checkOutput({tag, ".req_ready"}, 32'(req_ready), 32'(expReady));
    checkOutput({tag, ".sh_in"},     sh_in,          expIn);
    checkOutput({tag, ".sh_sel"},    32'(sh_sel),    32'(expSel));
    checkOutput({tag, ".sh_B"},      32'(sh_B),      32'(expAmt));
    @(posedge clk);
    #1;
    if (w >= 0) begin
      mData  = refShift(opData[w], opSel[w], opAmt[w]);
      mId    = w;
      mValid = 1'b1;
      mPtr   = (w + 1) % N;
    end else if (rsp_ready) begin
      mValid = 1'b0;
    end
    lastWinner = w;
    checkOutput({tag, ".rsp_valid"}, 32'(rsp_valid), 32'(mValid));
    checkOutput({tag, ".rsp_data"},  rsp_data,       mData);
    checkOutput({tag, ".rsp_id"},    32'(rsp_id),    32'(mId));
  endtask

  task automatic clearRequests();
    for (int i = 0; i < N; i++) begin
      opValid[i] = 1'b0;
      opData[i]  = '0;
      opSel[i]   = '0;
      opAmt[i]   = '0;
    end
  endtask

  task automatic setRequest(input int i, input logic [31:0] d, input logic [1:0] s,
                            input logic [4:0] a);
    opValid[i] = 1'b1;
    opData[i]  = d;
    opSel[i]   = s;
    opAmt[i]   = a;
  endtask

  // Asynchronous reset pulse, released one time unit after a rising edge.
  task automatic doReset();
    rst = 1'b1;
    #1;
    checkOutput("reset.rsp_valid", 32'(rsp_valid), 32'd0);
    @(posedge clk);
    #1;
    rst    = 1'b0;
    mPtr   = 0;
    mValid = 1'b0;
    mData  = '0;
    mId    = 0;
  endtask

  initial begin
    clearRequests();
    for (int i = 0; i < N; i++) setRequest(i, 32'hFFFF_FFFF, 2'b11, 5'd7);

    // Reset state with every requester asking: no grant may leak out.
    #2;
    checkOutput("init.req_ready", 32'(req_ready), 32'd0);
    checkOutput("init.rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("init.rsp_data",  rsp_data,       32'd0);
    checkOutput("init.rsp_id",    32'(rsp_id),    32'd0);
    checkOutput("init.sh_in",     sh_in,          32'd0);
    checkOutput("init.sh_sel",    32'(sh_sel),    32'd0);
    checkOutput("init.sh_B",      32'(sh_B),      32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Requester 0 alone, arithmetic right.
    clearRequests();
    rsp_ready = 1'b1;
    setRequest(0, 32'h8000_0000, 2'b01, 5'd4);
    applyStimulus("req0");
    checkOutput("req0.lit_data", rsp_data,    32'hF800_0000);
    checkOutput("req0.lit_id",   32'(rsp_id), 32'd0);

    // Requester 2 alone, logical left.
    clearRequests();
    setRequest(2, 32'h0000_0001, 2'b10, 5'd31);
    applyStimulus("lsl");
    checkOutput("lsl.lit_data", rsp_data,    32'h8000_0000);
    checkOutput("lsl.lit_id",   32'(rsp_id), 32'd2);

    // Mode 2'b11 passes through as a logical left.
    clearRequests();
    setRequest(1, 32'h8000_00F1, 2'b11, 5'd4);
    applyStimulus("sel11");
    checkOutput("sel11.lit_data", rsp_data, 32'h0000_0F10);

    // Drain with nothing requested empties the buffer.
    clearRequests();
    applyStimulus("drain");

`ifndef SHIFT_ARB_FIXED_PRIO_EN
    // Round-robin with all four requesters held valid.
    doReset();
    for (int i = 0; i < N; i++) setRequest(i, 32'h1234_5678 + i, 2'(i), 5'(i + 1));
    for (int k = 0; k < 5; k++) begin
      applyStimulus("rr");
      checkOutput("rr.lit_id", 32'(rsp_id), 32'(rrOrder[k]));
    end

    // Backpressure with requesters 1 and 3.
    doReset();
    clearRequests();
    setRequest(1, 32'hF000_000F, 2'b00, 5'd4);
    setRequest(3, 32'h0000_0003, 2'b10, 5'd8);
    rsp_ready = 1'b0;
    applyStimulus("bp.first");
    checkOutput("bp.first_id", 32'(rsp_id), 32'd1);
    for (int k = 0; k < 3; k++) begin
      applyStimulus("bp.stall");
      checkOutput("bp.hold_data", rsp_data, 32'h0F00_0000);
    end
    rsp_ready = 1'b1;
    applyStimulus("bp.release");
    checkOutput("bp.next_id",    32'(rsp_id),    32'd3);
    checkOutput("bp.next_valid", 32'(rsp_valid), 32'd1);
`else
    // Fixed priority: requester 0 wins every cycle over requester 1.
    doReset();
    clearRequests();
    setRequest(0, 32'h0000_0010, 2'b00, 5'd1);
    setRequest(1, 32'h0000_0020, 2'b00, 5'd1);
    for (int k = 0; k < 4; k++) begin
      applyStimulus("fixed");
      checkOutput("fixed.lit_id", 32'(rsp_id), 32'd0);
    end
`endif

    // Make sure a response is pending, then reset between clock edges.
    clearRequests();
    setRequest(2, 32'hAAAA_5555, 2'b00, 5'd1);
    rsp_ready = 1'b0;
    applyStimulus("preRst");
    for (int i = 0; i < N; i++) setRequest(i, 32'h0000_0100 << i, 2'b10, 5'd2);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midRst.rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("midRst.req_ready", 32'(req_ready), 32'd0);
    checkOutput("midRst.rsp_data",  rsp_data,       32'd0);
    @(posedge clk);
    #1;
    rst    = 1'b0;
    mPtr   = 0;
    mValid = 1'b0;
    mData  = '0;
    mId    = 0;
    rsp_ready = 1'b1;
    applyStimulus("postRst");
    checkOutput("postRst.lit_id", 32'(rsp_id), 32'd0);

    // Randomized traffic: requests stay stable until granted.
    clearRequests();
    for (int c = 0; c < 400; c++) begin
      rsp_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++)
        if (!opValid[i] && $urandom_range(0, 2) == 0)
          setRequest(i, $urandom, 2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)));
      applyStimulus("rand");
      if (lastWinner >= 0) opValid[lastWinner] = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_arbiter.md
# shift_arbiter

Shares one 32-bit barrel shifter between NUM_REQ requesters in the pipelined core, for example the ALU lane and the address/CSR helper lanes. Each cycle it grants at most one pending request by round-robin and drives the selected operand, mode and amount onto the shifter's combinational inputs. The shifter result is captured with the winner's ID in a single-entry response register that is drained by a valid/ready handshake.

## Interface
Parameters:
- NUM_REQ, default 4: number of requesters, legal range 2..8.
- IDW, default $clog2(NUM_REQ): width of the requester ID.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  reset; asynchronous and active-high.
- req_valid  in  NUM_REQ  request pending, one bit per requester.
- req_ready  out  NUM_REQ  one-hot grant; a transfer completes when req_valid[i] and req_ready[i] are both high.
- req_data  in  NUM_REQ*32  operands; requester i uses bits [32i+31:32i].
- req_sel  in  NUM_REQ*2  shift mode per requester; bit 1 = left, bit 0 = arithmetic.
- req_amt  in  NUM_REQ*5  shift amount per requester.
- sh_in  out  32  operand to the shifter.
- sh_sel  out  2  mode to the shifter.
- sh_B  out  5  amount to the shifter.
- sh_out  in  32  combinational result from the shifter.
- rsp_valid  out  1  response register holds a result.
- rsp_ready  in  1  consumer accepts the response.
- rsp_data  out  32  shifted result.
- rsp_id  out  IDW  index of the requester that owns rsp_data.

## Operation
- Response buffer state:
  - EMPTY when rsp_valid=0; FULL when rsp_valid=1.
  - can_issue = ~rsp_valid | rsp_ready.
- Arbitration is combinational.
  - When can_issue=1 and req_valid≠0, exactly one req_ready bit is high.
  - The winner is the first valid requester, searching upward from the priority pointer ptr and wrapping modulo NUM_REQ.
- Shifter drive:
  - sh_in, sh_sel and sh_B carry the winner's fields.
  - When no requester is granted they are all 0.
- On a granted cycle, at the rising edge:
  - rsp_data ← sh_out, rsp_id ← winner index, rsp_valid ← 1.
  - ptr ← (winner + 1) mod NUM_REQ.
- On a cycle where rsp_ready=1 and nothing is granted: rsp_valid ← 0. rsp_data and rsp_id hold their values.
- When FULL and rsp_ready=0:
  - All req_ready bits are 0.
  - The response register and ptr hold.
  - Requesters keep req_valid and their fields stable until granted.
- Simultaneous drain and grant in the same cycle: the new result replaces the old one and rsp_valid stays 1.
- sel=2'b11 is passed through unchanged; the shifter treats it as a logical left shift.
- Reset asserted mid-operation:
  - An in-flight response is discarded and ptr returns to 0.
  - req_ready is forced to 0 for as long as rst is high.
- Reset values: rsp_valid=0, rsp_data=0, rsp_id=0, ptr=0, req_ready=0, sh_in/sh_sel/sh_B=0.

## Timing
- Grant is combinational, in the same cycle as req_valid.
- Latency from grant to rsp_valid is 1 cycle.
- Throughput is 1 result per cycle while rsp_ready=1.
- The combinational path is: req_valid → arbiter → mux → shifter → rsp_data D input. This path is sized to close at core frequency.
- No path runs combinationally from rsp_ready to rsp_valid. req_ready does depend combinationally on rsp_ready.

## Configuration
- SHIFT_ARB_FIXED_PRIO_EN
  - Defined: fixed priority; the lowest index wins. ptr is not implemented and is treated as constant 0.
  - Undefined (default): round-robin as described in Operation.
- The handshake and latency are identical in both builds.

## Test plan
- Requester 0 alone:
  - Stimulus: data=0x8000_0000, sel=2'b01, amt=4, rsp_ready=1.
  - Required: req_ready[0] high in the same cycle; one cycle later rsp_valid=1, rsp_data=0xF800_0000, rsp_id=0.
- Logical left:
  - Stimulus: requester 2 sends data=0x0000_0001, sel=2'b10, amt=31.
  - Required: rsp_data=0x8000_0000, rsp_id=2.
- Round-robin:
  - Stimulus: all 4 requesters hold valid continuously, rsp_ready=1.
  - Required: grants in order 0,1,2,3,0 on consecutive cycles, one response per cycle, rsp_id matching the grant order.
- Backpressure:
  - Stimulus: rsp_ready=0 for 3 cycles while requesters 1 and 3 are valid.
  - Required: the first response is held stable and req_ready stays 0. When rsp_ready rises, the next grant goes to requester 3 (ptr=2), it is issued that same cycle, and rsp_valid stays high.
- Reset mid-operation:
  - Stimulus: assert rst asynchronously while rsp_valid=1.
  - Required: rsp_valid=0 immediately, without waiting for a clock edge. After release the first grant goes to requester 0.
- With SHIFT_ARB_FIXED_PRIO_EN defined:
  - Stimulus: requesters 0 and 1 both held valid.
  - Required: requester 0 is granted every cycle and requester 1 is never granted.
